// File: rtl/memory_arbiter_rr.sv
// Round-robin memory arbiter: N cache channels share one RAM port with a burst scratchpad.
// Optional build macro ARBITER_STARVE_GUARD_EN bounds how long a cache can wait behind bursts.
module memory_arbiter_rr #(
  parameter int NREQ       = 2,
  parameter int BEATS      = 8,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STRIDE     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*WORD_W-1:0]   req_store,
  output logic [NREQ-1:0]          req_wait,
  output logic [WORD_W-1:0]        req_load,
  input  logic                     sp_load,
  input  logic                     sp_store,
  input  logic [ADDR_W-1:0]        sp_addr,
  input  logic [BEATS*WORD_W-1:0]  sp_store_data,
  output logic [BEATS*WORD_W-1:0]  sp_load_data,
  output logic                     sp_load_done,
  output logic                     sp_store_done,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  logic                     ramBUSY,
  input  logic [WORD_W-1:0]        ramload
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, CACHE, SP_LD, SP_ST} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [BEATS*WORD_W-1:0]  sp_load_data_q, sp_load_data_d;
  logic                     sp_load_done_q, sp_load_done_d;
  logic                     sp_store_done_q, sp_store_done_d;

  logic [NREQ-1:0]          cache_req;
  logic                     rr_found;
  logic [IDX_W-1:0]         rr_idx;
  logic [ADDR_W-1:0]        beat_off;
  logic                     cache_grant;
  logic                     sp_grant;
  logic                     starve_hit;

  assign cache_req = req_ren | req_wen;
  assign beat_off  = ADDR_W'(beat_q) * ADDR_W'(STRIDE);

  // First requesting channel at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && cache_req[(int'(rr_ptr_q) + k) % NREQ]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

`ifdef ARBITER_STARVE_GUARD_EN
  localparam int STV_W = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);

  logic [STV_W-1:0] starve_q, starve_d;

  assign starve_hit = rr_found && (starve_q == STV_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (cache_grant)
      starve_d = '0;
    else if (sp_grant && rr_found)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  // STARVE_MAX only has an effect when the guard is built in.
  assign starve_hit = (STARVE_MAX < 0);
`endif

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    beat_d          = beat_q;
    sp_load_data_d  = sp_load_data_q;
    sp_load_done_d  = 1'b0;
    sp_store_done_d = 1'b0;
    cache_grant     = 1'b0;
    sp_grant        = 1'b0;
    ramaddr         = '0;
    ramstore        = '0;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    req_wait        = '1;
    req_load        = '0;
    case (state_q)
      IDLE: begin
        if (starve_hit) begin
          cache_grant = 1'b1;
          grant_d     = rr_idx;
          state_d     = CACHE;
        end else if (sp_load) begin
          sp_grant = 1'b1;
          beat_d   = '0;
          state_d  = SP_LD;
        end else if (sp_store) begin
          sp_grant = 1'b1;
          beat_d   = '0;
          state_d  = SP_ST;
        end else if (rr_found) begin
          cache_grant = 1'b1;
          grant_d     = rr_idx;
          state_d     = CACHE;
        end
      end
      CACHE: begin
        ramaddr  = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
        ramstore = req_store[int'(grant_q)*WORD_W +: WORD_W];
        ramREN   = req_ren[grant_q];
        ramWEN   = req_wen[grant_q] & ~req_ren[grant_q];
        if (!cache_req[grant_q]) begin
          state_d = IDLE;
        end else if (!ramBUSY) begin
          req_wait[grant_q] = 1'b0;
          if (req_ren[grant_q]) req_load = ramload;
          rr_ptr_d = IDX_W'((int'(grant_q) + 1) % NREQ);
          state_d  = IDLE;
        end
      end
      SP_LD: begin
        if (!sp_load) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = sp_addr + beat_off;
          if (!ramBUSY) begin
            sp_load_data_d[int'(beat_q)*WORD_W +: WORD_W] = ramload;
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              sp_load_done_d = 1'b1;
              beat_d         = '0;
              state_d        = IDLE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
      end
      SP_ST: begin
        if (!sp_store) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = sp_addr + beat_off;
          ramstore = sp_store_data[int'(beat_q)*WORD_W +: WORD_W];
          if (!ramBUSY) begin
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              sp_store_done_d = 1'b1;
              beat_d          = '0;
              state_d         = IDLE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      beat_q          <= '0;
      sp_load_data_q  <= '0;
      sp_load_done_q  <= 1'b0;
      sp_store_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      beat_q          <= beat_d;
      sp_load_data_q  <= sp_load_data_d;
      sp_load_done_q  <= sp_load_done_d;
      sp_store_done_q <= sp_store_done_d;
    end
  end

  assign sp_load_data  = sp_load_data_q;
  assign sp_load_done  = sp_load_done_q;
  assign sp_store_done = sp_store_done_q;

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Directed bench for memory_arbiter_rr: round-robin, bursts, aborts, reset and starve guard.
module tb_memory_arbiter_rr;

  logic          CLK;
  logic          nRST;
  logic [1:0]    req_ren;
  logic [1:0]    req_wen;
  logic [63:0]   req_addr;
  logic [63:0]   req_store;
  logic [1:0]    req_wait;
  logic [31:0]   req_load;
  logic          sp_load;
  logic          sp_store;
  logic [31:0]   sp_addr;
  logic [255:0]  sp_store_data;
  logic [255:0]  sp_load_data;
  logic          sp_load_done;
  logic          sp_store_done;
  logic [31:0]   ramaddr;
  logic [31:0]   ramstore;
  logic          ramREN;
  logic          ramWEN;
  logic          ramBUSY;
  logic [31:0]   ramload;

  int n_checks = 0;
  int n_errors = 0;

  memory_arbiter_rr dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .sp_load(sp_load), .sp_store(sp_store), .sp_addr(sp_addr),
    .sp_store_data(sp_store_data), .sp_load_data(sp_load_data),
    .sp_load_done(sp_load_done), .sp_store_done(sp_store_done),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramBUSY(ramBUSY), .ramload(ramload)
  );

  // Memory returns a tag plus the low address bits it was asked for.
  assign ramload = {16'hD00D, ramaddr[15:0]};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  logic [1:0] rr_exp [8];
  int wen_cnt, wr_cnt, done_cnt, grant_at, dones_at_grant;
  logic granted;

  initial begin
    nRST = 1'b1; req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
    sp_load = 1'b0; sp_store = 1'b0; sp_addr = '0; sp_store_data = '0; ramBUSY = 1'b0;
    for (int k = 0; k < 8; k++) sp_store_data[k*32 +: 32] = 32'h5000_0000 + k;
    rr_exp = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
    #2 nRST = 1'b0;
    #1;
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_wait", req_wait, 2'b11);
    chk("rst_load", req_load, 0);
    chk("rst_ldone", sp_load_done, 0);
    chk("rst_sdone", sp_store_done, 0);
    chk("rst_data", |sp_load_data, 0);
    cyc(); cyc();
    nRST = 1'b1;

    // Both channels reading continuously
    cyc();
    req_ren = 2'b11; req_addr = {32'h0000_0080, 32'h0000_0040};
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin cyc(); #1; end
      chk($sformatf("rr_wait%0d", i), req_wait, rr_exp[i]);
      if (i == 1) begin
        chk("rr_addr0", ramaddr, 32'h40);
        chk("rr_load0", req_load, 32'hD00D_0040);
      end
      if (i == 3) chk("rr_addr1", ramaddr, 32'h80);
    end
    cyc(); req_ren = 2'b00; #1;
    chk("rr_idle", req_wait, 2'b11);

    // Granted channel withdraws while memory is busy
    cyc(); req_ren = 2'b01; ramBUSY = 1'b1; #1;
    chk("drop_idle", req_wait, 2'b11);
    cyc(); #1;
    chk("drop_busy_ren", ramREN, 1);
    chk("drop_busy_wait", req_wait, 2'b11);
    cyc(); req_ren = 2'b00; #1;
    chk("drop_ren", ramREN, 0);
    chk("drop_wait", req_wait, 2'b11);
    cyc(); req_ren = 2'b11; ramBUSY = 1'b0; #1;
    chk("drop_back_idle", req_wait, 2'b11);
    cyc(); #1;
    chk("drop_rr_kept", req_wait, 2'b10);
    cyc(); req_ren = 2'b00; #1;

    // Scratchpad burst load
    cyc(); sp_addr = 32'h100; sp_load = 1'b1; #1;
    chk("ld_idle_ren", ramREN, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      chk($sformatf("ld_addr%0d", k), ramaddr, 32'h100 + 4*k);
      chk($sformatf("ld_ren%0d", k), ramREN, 1);
    end
    chk("ld_done_early", sp_load_done, 0);
    cyc(); sp_load = 1'b0; #1;
    chk("ld_done", sp_load_done, 1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("ld_slot%0d", k), sp_load_data[k*32 +: 32], 32'hD00D_0100 + 4*k);
    cyc(); #1;
    chk("ld_done_once", sp_load_done, 0);

    // Scratchpad burst store, 2 busy cycles per beat
    cyc(); sp_addr = 32'h200; sp_store = 1'b1; #1;
    wen_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(); ramBUSY = (j < 2); #1;
        if (ramWEN) wen_cnt++;
        if (ramWEN && !ramBUSY) wr_cnt++;
        if (sp_store_done) done_cnt++;
        if (ramREN) done_cnt = done_cnt + 100;
        if (j == 2) begin
          chk($sformatf("st_addr%0d", k), ramaddr, 32'h200 + 4*k);
          chk($sformatf("st_data%0d", k), ramstore, 32'h5000_0000 + k);
        end
      end
    end
    cyc(); sp_store = 1'b0; ramBUSY = 1'b0; #1;
    chk("st_done", sp_store_done, 1);
    chk("st_wen_cycles", wen_cnt, 24);
    chk("st_writes", wr_cnt, 8);
    chk("st_no_early_done", done_cnt, 0);
    cyc(); #1;
    chk("st_done_once", sp_store_done, 0);

    // Burst load aborted after three beats
    cyc(); sp_addr = 32'h300; sp_load = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin cyc(); #1; end
    cyc(); sp_load = 1'b0; #1;
    chk("ab_ren", ramREN, 0);
    cyc(); #1;
    chk("ab_no_done", sp_load_done, 0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("ab_slot%0d", k), sp_load_data[k*32 +: 32], 32'hD00D_0300 + 4*k);
    chk("ab_keep3", sp_load_data[3*32 +: 32], 32'hD00D_010C);

    // Load and store together: load wins and restarts at beat 0
    cyc(); sp_load = 1'b1; sp_store = 1'b1; #1;
    cyc(); sp_store = 1'b0; #1;
    chk("prio_ren", ramREN, 1);
    chk("prio_wen", ramWEN, 0);
    chk("prio_addr", ramaddr, 32'h300);
    for (int k = 1; k < 5; k++) begin cyc(); #1; end
    cyc(); #1;
    chk("b5_addr", ramaddr, 32'h314);
    nRST = 1'b0; #1;
    chk("mrst_ren", ramREN, 0);
    chk("mrst_wait", req_wait, 2'b11);
    chk("mrst_done", sp_load_done, 0);
    chk("mrst_data", |sp_load_data, 0);
    cyc(); sp_load = 1'b0; nRST = 1'b1; #1;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      if (sp_load_done || ramREN) done_cnt++;
    end
    chk("mrst_quiet", done_cnt, 0);

    // Continuous scratchpad loads against a waiting cache reader
    cyc(); sp_addr = 32'h100; sp_load = 1'b1; req_ren = 2'b10; #1;
    granted = 1'b0; grant_at = -1; dones_at_grant = -1; done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) begin cyc(); #1; end
      if (!req_wait[1] && !granted) begin
        granted = 1'b1; grant_at = i; dones_at_grant = done_cnt;
      end
      if (sp_load_done) done_cnt++;
    end
`ifdef ARBITER_STARVE_GUARD_EN
    chk("guard_granted", granted, 1);
    chk("guard_grant_cycle", grant_at, 28);
    chk("guard_bursts_before", dones_at_grant, 3);
`else
    chk("noguard_granted", granted, 0);
    chk("noguard_bursts", done_cnt, 6);
`endif
    cyc(); sp_load = 1'b0; req_ren = 2'b00; #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter_rr.md
MEMORY_ARBITER_RR -- requirements
Module: memory_arbiter_rr

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  NREQ  2  number of cache requester channels (>=2).
  BEATS  8  words per scratchpad burst (power of 2, 2..16).
  WORD_W  32  data word width.
  ADDR_W  32  byte address width.
  STRIDE  4  byte address increment per beat.
  STARVE_MAX  3  scratchpad bursts allowed while a cache waits (guard only).
REQ-002 Ports, one per line: name  direction  width  meaning.
  CLK  in  1  clock, rising edge.
  nRST  in  1  reset, asynchronous, active-low.
  req_ren  in  NREQ  per-channel read request.
  req_wen  in  NREQ  per-channel write request; a channel asserts at most one of req_ren/req_wen.
  req_addr  in  NREQ*ADDR_W  per-channel address; channel i is bits [i*ADDR_W +: ADDR_W].
  req_store  in  NREQ*WORD_W  per-channel write data.
  req_wait  out  NREQ  per-channel wait; 0 for exactly one cycle on completion.
  req_load  out  WORD_W  read data, valid in the cycle the granted req_wait is 0.
  sp_load  in  1  scratchpad burst-load request, level, held until done.
  sp_store  in  1  scratchpad burst-store request, level, held until done.
  sp_addr  in  ADDR_W  burst base address.
  sp_store_data  in  BEATS*WORD_W  burst write data; beat k is bits [k*WORD_W +: WORD_W].
  sp_load_data  out  BEATS*WORD_W  registered burst read data.
  sp_load_done  out  1  one-cycle registered pulse when the burst load completes.
  sp_store_done  out  1  one-cycle registered pulse when the burst store completes.
  ramaddr  out  ADDR_W  memory address.
  ramstore  out  WORD_W  memory write data.
  ramREN  out  1  memory read enable.
  ramWEN  out  1  memory write enable.
  ramBUSY  in  1  memory busy; an access completes in a cycle where ramBUSY=0.
  ramload  in  WORD_W  memory read data, valid when ramBUSY=0.

Function
REQ-003 States: IDLE, CACHE, SP_LD, SP_ST; state and all counters registered.
REQ-004 IDLE: ram outputs all 0; all req_wait=1; req_load=0.
REQ-005 IDLE priority: sp_load, then sp_store, then cache channels; sp_load and sp_store together selects load.
REQ-006 Cache selection is round-robin: first requesting channel at or after rr_ptr (mod NREQ); grant index latched; move to CACHE.
REQ-007 CACHE: drive ramaddr, ramstore, ramREN, ramWEN from the granted channel; when ramBUSY=0, req_wait[g]=0 and req_load=ramload (reads); rr_ptr<=(g+1) mod NREQ; return to IDLE.
REQ-008 CACHE: if the granted channel drops both ren and wen, return to IDLE with no completion and rr_ptr unchanged.
REQ-009 SP_LD: beat counter b starts at 0; ramREN=1, ramaddr=sp_addr+b*STRIDE (modulo 2^ADDR_W); on ramBUSY=0 capture ramload into slot b and increment b.
REQ-010 SP_LD: on completion of beat BEATS-1, sp_load_done=1 in the next cycle, b<=0, return to IDLE.
REQ-011 SP_ST: same sequencing with ramWEN=1 and ramstore=beat b of sp_store_data; completion pulses sp_store_done.
REQ-012 If sp_load (sp_load) or sp_store (sp_store) drops mid-burst, abort to IDLE, b<=0, no done pulse; slots already captured in sp_load_data are retained.
REQ-013 ramREN and ramWEN are never both 1; at most one req_wait bit is 0 in any cycle.

Reset
REQ-014 nRST=0 asynchronously sets state=IDLE, rr_ptr=0, b=0, sp_load_data=0, sp_load_done=0, sp_store_done=0, starve counter=0; outputs take the IDLE values of REQ-004.
REQ-015 Reset mid-burst or mid-access discards the operation; no done pulse or req_wait=0 follows.

Configuration
REQ-016 Macro ARBITER_STARVE_GUARD_EN.
  Defined: a 2-bit-or-wider counter increments per scratchpad burst granted while any cache request is pending; when the counter equals STARVE_MAX, the next IDLE grant goes to a pending cache channel; the counter clears on any cache grant.
  Undefined: scratchpad always wins per REQ-005; no counter logic.

Verification
REQ-017 Directed scenarios:
  Channels 0 and 1 read continuously, ramBUSY=0 -> grants alternate 0,1,0,1; each req_wait low for 1 cycle.
  sp_load, sp_addr=0x100, BEATS=8, ramBUSY=0 -> addresses 0x100..0x11C step 4; sp_load_done pulses 1 cycle after beat 7; slots match ramload.
  sp_store with ramBUSY=1 for 2 cycles per beat -> each beat held 3 cycles; 8 writes; a single sp_store_done pulse.
  sp_load drops after beat 3 -> IDLE next cycle, no done pulse, slots 0..2 retained.
  Guard on, STARVE_MAX=3, sp_load continuous, channel 1 reading -> channel 1 granted after 3 bursts; guard off -> never granted.
  nRST low during SP_LD beat 5 -> outputs at reset values immediately; no done pulse.
